// File: rtl/gb_apu_pkg.sv
// -----------------------------------------------------------------------------
// gb_apu_pkg
//   Shared constants for the Game Boy APU frame sequencer.
//   - FRAME_STEPS  : number of steps in one sequencer frame (8)
//   - *_STEPS      : per-unit step masks, bit n set = unit clocked on step n
//   - strobes_t    : packed bundle of the three unit strobes
//   - decode_step  : looks up which strobes fire on a given step
// -----------------------------------------------------------------------------
package gb_apu_pkg;

   localparam int unsigned FRAME_STEPS = 8;
   localparam int unsigned STEP_W      = $clog2(FRAME_STEPS);

   typedef logic [STEP_W-1:0] step_t;

   // Bit n corresponds to step n.
   localparam logic [FRAME_STEPS-1:0] LENGTH_STEPS = 8'b0101_0101;
   localparam logic [FRAME_STEPS-1:0] SWEEP_STEPS  = 8'b0100_0100;
   localparam logic [FRAME_STEPS-1:0] ENV_STEPS    = 8'b1000_0000;

   typedef struct packed {
      logic length;
      logic sweep;
      logic env;
   } strobes_t;

   // Single table-driven decode; the masks are the only place the step
   // schedule lives.
   function automatic strobes_t decode_step(input step_t step);
      strobes_t s;
      s.length = LENGTH_STEPS[step];
      s.sweep  = SWEEP_STEPS[step];
      s.env    = ENV_STEPS[step];
      return s;
   endfunction

endpackage

// File: rtl/gb_apu_falling_edge_detect.sv
// -----------------------------------------------------------------------------
// gb_apu_falling_edge_detect
//   Registers 'in' every clock and produces a combinational one-cycle pulse
//   when a 1 -> 0 transition is seen and 'enable' is high. The history
//   register keeps tracking 'in' even while disabled, so re-enabling never
//   produces a pulse for an edge that happened while disabled.
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset (history register clears to 0)
//     in     : monitored signal
//     enable : gates the output pulse
//     pulse  : high for the cycle in which a falling edge is sampled
// -----------------------------------------------------------------------------
module gb_apu_falling_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic enable,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   // Resetting the history to 0 means a low input right after reset can
   // never look like a falling edge.
   assign pulse = in_q & ~in & enable;

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gb_apu_frame_sequencer
//   Eight-step APU frame sequencer driven by a 512 Hz tick. Each tick executes
//   step frame_step and advances it modulo 8; the executed step raises the
//   length (256 Hz), sweep (128 Hz) and/or envelope (64 Hz) strobes for
//   exactly one clock, one clock after the tick is sampled.
//
//   Tick source:
//     default                          : falling edge of div_bit
//     GB_APU_FRAME_SEQ_INTERNAL_DIV_EN : internal free-running divider of
//                                        CLK_PER_TICK clocks; div_bit ignored
//
//   Ports:
//     clk            : system clock (4.194304 MHz nominal)
//     rst_n          : asynchronous active-low reset
//     apu_enable     : APU master enable; low holds step 0, strobes low
//     div_bit        : DIV-APU source bit, falling edge = one tick
//     clk_length_ctr : length-counter strobe
//     clk_sweep      : frequency-sweep strobe
//     clk_vol_env    : volume-envelope strobe
//     frame_step     : index of the next step to execute (also the
//                      sequencer's observable state)
// -----------------------------------------------------------------------------
module gb_apu_frame_sequencer
   import gb_apu_pkg::*;
#(
   parameter int unsigned CLK_PER_TICK = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        apu_enable,
   input  logic        div_bit,
   output logic        clk_length_ctr,
   output logic        clk_sweep,
   output logic        clk_vol_env,
   output logic [2:0]  frame_step
);

   logic     tick;
   strobes_t strobes_q;
   step_t    step_q;

   // The divider needs at least two states to produce a wrap.
   if (CLK_PER_TICK < 2) begin : g_bad_cfg
      $error("gb_apu_frame_sequencer: CLK_PER_TICK must be >= 2");
   end

`ifdef GB_APU_FRAME_SEQ_INTERNAL_DIV_EN
   localparam int unsigned CNT_W = $clog2(CLK_PER_TICK);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_TICK - 1);

   logic [CNT_W-1:0] div_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else if (!apu_enable) begin
         div_cnt_q <= '0;
      end else if (div_cnt_q == CNT_LAST) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + 1'b1;
      end
   end

   // The tick is taken on the edge where the counter wraps back to 0.
   assign tick = apu_enable && (div_cnt_q == CNT_LAST);
`else
   gb_apu_falling_edge_detect u_div_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (div_bit),
      .enable (apu_enable),
      .pulse  (tick)
   );
`endif

   // Strobes are registered from the step being executed, so they rise on the
   // same edge that advances frame_step and drop on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q    <= '0;
         strobes_q <= '0;
      end else if (!apu_enable) begin
         step_q    <= '0;
         strobes_q <= '0;
      end else if (tick) begin
         strobes_q <= decode_step(step_q);
         step_q    <= step_q + 1'b1;  // 3-bit wrap gives 7 -> 0
      end else begin
         strobes_q <= '0;
      end
   end

   assign clk_length_ctr = strobes_q.length;
   assign clk_sweep      = strobes_q.sweep;
   assign clk_vol_env    = strobes_q.env;
   assign frame_step     = step_q;

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gb_apu_frame_sequencer
//   Directed bench for gb_apu_frame_sequencer. Inputs are driven and outputs
//   sampled on the falling clock edge, away from the active rising edge.
//   The default build exercises the div_bit path; building with
//   GB_APU_FRAME_SEQ_INTERNAL_DIV_EN exercises the internal divider with
//   CLK_PER_TICK = 4.
// -----------------------------------------------------------------------------
module tb_gb_apu_frame_sequencer;

`ifdef GB_APU_FRAME_SEQ_INTERNAL_DIV_EN
   localparam int unsigned TB_CLK_PER_TICK = 4;
`else
   localparam int unsigned TB_CLK_PER_TICK = 8192;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       apu_enable = 1'b0;
   logic       div_bit = 1'b0;
   logic       clk_length_ctr;
   logic       clk_sweep;
   logic       clk_vol_env;
   logic [2:0] frame_step;

   always #5 clk = ~clk;

   gb_apu_frame_sequencer #(
      .CLK_PER_TICK (TB_CLK_PER_TICK)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .apu_enable     (apu_enable),
      .div_bit        (div_bit),
      .clk_length_ctr (clk_length_ctr),
      .clk_sweep      (clk_sweep),
      .clk_vol_env    (clk_vol_env),
      .frame_step     (frame_step)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int model_step = 0;
   int len_cnt = 0;
   int sweep_cnt = 0;
   int env_cnt = 0;
   logic [2:0] exp_q[$];

   // Strobe pulse counters, one count per sampled high cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         len_cnt   = len_cnt + int'(clk_length_ctr);
         sweep_cnt = sweep_cnt + int'(clk_sweep);
         env_cnt   = env_cnt + int'(clk_vol_env);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hand-written step schedule: length on even steps, sweep on 2 and 6,
   // envelope on 7. Packed as {length, sweep, env}.
   function automatic logic [2:0] step_strobes(input int s);
      logic [2:0] r;
      r[2] = (s % 2 == 0);
      r[1] = (s == 2) || (s == 6);
      r[0] = (s == 7);
      return r;
   endfunction

   function automatic logic [2:0] strobes_now();
      return {clk_length_ctr, clk_sweep, clk_vol_env};
   endfunction

`ifndef GB_APU_FRAME_SEQ_INTERNAL_DIV_EN
   // ---------------- driver tasks ----------------
   // One div_bit falling edge; checks the strobes of the executed step one
   // clock later, that they last exactly one clock, and the new frame_step.
   task automatic edge_and_check(input string tag);
      logic [2:0] exp;
      div_bit = 1'b1;
      repeat (2) @(negedge clk);
      div_bit = 1'b0;
      exp_q.push_back(step_strobes(model_step));
      @(negedge clk);
      exp = exp_q.pop_front();
      check({tag, "_strobe"}, 32'(strobes_now()), 32'(exp));
      check({tag, "_step"}, 32'(frame_step), 32'((model_step + 1) % 8));
      @(negedge clk);
      check({tag, "_width"}, 32'(strobes_now()), 32'd0);
      model_step = (model_step + 1) % 8;
   endtask
`endif

   int l0, s0, e0;

   initial begin
      apu_enable = 1'b1;
      div_bit    = 1'b0;
      rst_n      = 1'b0;

`ifndef GB_APU_FRAME_SEQ_INTERNAL_DIV_EN
      // ---- reset held: div_bit toggles must not move anything ----
      for (int i = 0; i < 10; i++) begin
         div_bit = ~div_bit;
         @(negedge clk);
         check("rst_strobes", 32'(strobes_now()), 32'd0);
         check("rst_step", 32'(frame_step), 32'd0);
      end
      // Release with div_bit low: no tick in the first clock.
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_no_tick", 32'(strobes_now()), 32'd0);
      @(negedge clk);
      check("post_rst_step", 32'(frame_step), 32'd0);

      // ---- 16 falling edges: two full frames ----
      l0 = len_cnt; s0 = sweep_cnt; e0 = env_cnt;
      model_step = 0;
      for (int i = 0; i < 16; i++) edge_and_check($sformatf("frame_e%0d", i + 1));
      check("frame_len_total", 32'(len_cnt - l0), 32'd8);
      check("frame_sweep_total", 32'(sweep_cnt - s0), 32'd4);
      check("frame_env_total", 32'(env_cnt - e0), 32'd2);
      check("frame_end_step", 32'(frame_step), 32'd0);

      // ---- steady high, then rising edges only ----
      l0 = len_cnt; s0 = sweep_cnt; e0 = env_cnt;
      div_bit = 1'b1;
      repeat (100) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         // Lower div_bit while disabled so only the rising edge is seen enabled.
         apu_enable = 1'b0;
         div_bit = 1'b0;
         repeat (2) @(negedge clk);
         apu_enable = 1'b1;
         repeat (2) @(negedge clk);
         div_bit = 1'b1;
         repeat (3) @(negedge clk);
      end
      check("rise_len", 32'(len_cnt - l0), 32'd0);
      check("rise_sweep", 32'(sweep_cnt - s0), 32'd0);
      check("rise_env", 32'(env_cnt - e0), 32'd0);
      check("rise_step", 32'(frame_step), 32'd0);

      // ---- five edges, disable, re-enable restarts at step 0 ----
      model_step = 0;
      for (int i = 0; i < 5; i++) edge_and_check($sformatf("pre_dis_e%0d", i + 1));
      apu_enable = 1'b0;
      repeat (3) @(negedge clk);
      check("dis_step", 32'(frame_step), 32'd0);
      check("dis_strobes", 32'(strobes_now()), 32'd0);
      apu_enable = 1'b1;
      model_step = 0;
      l0 = len_cnt; e0 = env_cnt;
      for (int i = 0; i < 7; i++) edge_and_check($sformatf("reen_e%0d", i + 1));
      check("reen_no_env_yet", 32'(env_cnt - e0), 32'd0);
      edge_and_check("reen_e8");
      check("reen_env_on_8th", 32'(env_cnt - e0), 32'd1);
      check("reen_len_total", 32'(len_cnt - l0), 32'd4);

      // ---- tick sampled in the very first enabled clock ----
      apu_enable = 1'b0;
      div_bit = 1'b1;
      repeat (2) @(negedge clk);
      apu_enable = 1'b1;
      div_bit = 1'b0;
      @(negedge clk);
      check("first_en_tick", 32'(strobes_now()), 32'(step_strobes(0)));
      check("first_en_step", 32'(frame_step), 32'd1);
      model_step = 1;

      // ---- asynchronous reset at frame_step 6 ----
      for (int i = 0; i < 5; i++) edge_and_check($sformatf("pre_rst_e%0d", i + 2));
      check("pre_rst_step6", 32'(frame_step), 32'd6);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_step", 32'(frame_step), 32'd0);
      check("async_rst_strobes", 32'(strobes_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_step = 0;
      edge_and_check("after_rst_e1");
`else
      // ---- internal divider, CLK_PER_TICK = 4 ----
      apu_enable = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_step", 32'(frame_step), 32'd0);
      check("rst_strobes", 32'(strobes_now()), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("dis_strobes", 32'(strobes_now()), 32'd0);
      l0 = len_cnt; s0 = sweep_cnt; e0 = env_cnt;
      apu_enable = 1'b1;
      // Divider counts 0,1,2,3: first tick on the 4th enabled edge.
      repeat (3) @(negedge clk);
      check("idiv_pre_tick", 32'(strobes_now()), 32'd0);
      @(negedge clk);
      check("idiv_first_tick", 32'(strobes_now()), 32'(step_strobes(0)));
      check("idiv_first_step", 32'(frame_step), 32'd1);
      repeat (124) @(negedge clk);
      check("idiv_len_total", 32'(len_cnt - l0), 32'd16);
      check("idiv_sweep_total", 32'(sweep_cnt - s0), 32'd8);
      check("idiv_env_total", 32'(env_cnt - e0), 32'd4);
      check("idiv_end_step", 32'(frame_step), 32'd0);
      check("idiv_last_env", 32'(strobes_now()), 32'(step_strobes(7)));
      apu_enable = 1'b0;
      repeat (8) @(negedge clk);
      check("idiv_dis_len", 32'(len_cnt - l0), 32'd16);
      check("idiv_dis_step", 32'(frame_step), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit in case the stimulus ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: observed no completion, expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gb_apu_frame_sequencer.md
GB_APU_FRAME_SEQUENCER -- requirements
Module: gb_apu_frame_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_TICK, default 8192, clocks per 512 Hz tick; used only when GB_APU_FRAME_SEQ_INTERNAL_DIV_EN is defined.
REQ-002 SHALL have port clk, input, 1, system clock (4.194304 MHz nominal).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port apu_enable, input, 1, APU master enable; low holds the sequencer idle.
REQ-005 SHALL have port div_bit, input, 1, DIV-APU source bit; each falling edge is one 512 Hz tick; ignored when the macro is defined.
REQ-006 SHALL have port clk_length_ctr, output, 1, 256 Hz single-cycle length-counter strobe.
REQ-007 SHALL have port clk_sweep, output, 1, 128 Hz single-cycle frequency-sweep strobe.
REQ-008 SHALL have port clk_vol_env, output, 1, 64 Hz single-cycle envelope strobe; connects directly to the envelope function's clk_vol_env.
REQ-009 SHALL have port frame_step, output, 3, index of the next step to execute.

Function
REQ-010 SHALL register div_bit into div_bit_q every clock; tick = div_bit_q & ~div_bit & apu_enable.
REQ-011 SHALL, on the clock edge where tick is true, execute step frame_step and advance frame_step by 1 modulo 8 (7 wraps to 0).
REQ-012 SHALL map steps: length on 0,2,4,6; sweep on 2,6; envelope on 7; no strobe on 1,3,5.
REQ-013 SHALL register strobes so each is high for exactly one clock, starting at the edge that executes the step; latency from sampled falling edge to strobe is 1 clock.
REQ-014 SHALL hold all strobes low on any clock without a tick; a rising edge or a steady div_bit produces no tick.
REQ-015 SHALL, while apu_enable is low, synchronously force frame_step to 0 and all strobes to 0, while div_bit_q keeps tracking div_bit so no spurious tick occurs on re-enable.
REQ-016 SHALL process a tick in the first clock apu_enable is high; the first step after enable is step 0.
REQ-017 SHALL never assert more than one tick per falling edge regardless of its duration.

Reset
REQ-018 SHALL, while rst_n is low, asynchronously drive frame_step=0, div_bit_q=0, all strobes=0, internal divider=0.
REQ-019 SHALL treat reset mid-sequence identically; the first tick after release executes step 0.
REQ-020 SHALL not generate a tick in the first clock after reset release if div_bit is low (div_bit_q resets to 0).

Configuration
REQ-021 SHALL, with GB_APU_FRAME_SEQ_INTERNAL_DIV_EN defined, ignore div_bit and generate tick internally when a free-running counter (0..CLK_PER_TICK-1, width $clog2(CLK_PER_TICK)) wraps to 0 with apu_enable high; the counter is held at 0 while apu_enable is low.
REQ-022 SHALL, with the macro undefined, use the div_bit falling-edge path only and instantiate no internal counter.

Structure
REQ-023 SHALL place in package gb_apu_pkg: step-count constant (8), step masks LENGTH_STEPS=8'b0101_0101, SWEEP_STEPS=8'b0100_0100, ENV_STEPS=8'b1000_0000 (bit n = step n).
REQ-024 SHALL use sub-module gb_apu_falling_edge_detect (clk, rst_n, in, enable, pulse) for the div_bit tick path.
REQ-025 SHALL decode strobes from masks indexed by frame_step; no per-step case duplication.

Verification
REQ-026 SHALL cover: rst_n low, toggle div_bit 10 times -> all strobes 0, frame_step 0 throughout.
REQ-027 SHALL cover: 16 div_bit falling edges -> exactly 8 clk_length_ctr, 4 clk_sweep, 2 clk_vol_env pulses, each 1 clock wide; clk_vol_env on the 8th and 16th edges; frame_step 0 at end.
REQ-028 SHALL cover: div_bit held high 100 clocks, then 5 rising edges only -> zero strobes.
REQ-029 SHALL cover: 5 edges, drop apu_enable 3 clocks -> frame_step 0; re-enable, next edge -> clk_length_ctr pulse (step 0); clk_vol_env only on 8th edge after re-enable.
REQ-030 SHALL cover: assert rst_n low between clocks at frame_step 6 -> strobes and frame_step 0 before next clk edge; next edge executes step 0.
REQ-031 SHALL cover: macro defined, CLK_PER_TICK=4, apu_enable high 128 clocks -> 32 ticks, 16 length, 8 sweep, 4 envelope strobes.
